// File: rtl/spi_flash_burst.sv
// Burst-read SPI flash controller (mode 0): one request -> one CS-low transaction
// of command, 24-bit address, optional dummy clocks and 1..MAX_BURST read bytes.
module spi_flash_burst #(
   parameter int CLK_DIV   = 1,
   parameter int MAX_BURST = 16,
   parameter int FAST_READ = 0,
   parameter int CS_GAP    = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [23:0] req_addr,
   input  logic [((MAX_BURST > 1) ? $clog2(MAX_BURST) : 1)-1:0] req_len,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        rd_last,
   output logic        sclk,
   output logic        mosi,
   input  logic        miso,
   output logic        cs
);
   localparam int LEN_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [7:0]       CMD_BYTE = (FAST_READ != 0) ? 8'h0B : 8'h03;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((CS_GAP > 1) ? CS_GAP - 2 : 0);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_HOLD, S_GAP
   } state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  div_cnt;
   logic [4:0]        bit_cnt;
   logic [LEN_W-1:0]  byte_cnt, len_q;
   logic [31:0]       tx_shift;
   logic [6:0]        rx_shift;
   logic              tick, shifting, rise, fall, bit_end, byte_end, accept;

   assign req_ready = (state == S_IDLE);

   always_ff @(posedge clk) begin
      if (rstn) state <= S_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      tick       = (div_cnt == DIV_LAST);
      shifting   = (state == S_CMD) || (state == S_ADDR) ||
                   (state == S_DUMMY) || (state == S_READ);
      rise       = shifting && tick && !sclk;
      fall       = shifting && tick && sclk;
      bit_end    = (state == S_ADDR) ? (bit_cnt == 5'd23) : (bit_cnt == 5'd7);
      byte_end   = (state == S_READ) && (bit_cnt == 5'd7);
      accept     = (state == S_IDLE) && req_valid;
      case (state)
         S_IDLE:  if (req_valid) state_next = S_CMD;
         S_CMD:   if (fall && bit_end) state_next = S_ADDR;
         S_ADDR:  if (fall && bit_end) state_next = (FAST_READ != 0) ? S_DUMMY : S_READ;
         S_DUMMY: if (fall && bit_end) state_next = S_READ;
         S_READ:  if (fall && byte_end && (byte_cnt == len_q)) state_next = S_HOLD;
         // GAP holds CS_GAP-1 cycles so req_ready is seen high exactly CS_GAP edges after cs rises
         S_HOLD:  if (tick) state_next = (CS_GAP > 1) ? S_GAP : S_IDLE;
         S_GAP:   if (div_cnt == GAP_LAST) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs       <= 1'b1;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
      end else begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         if (accept) begin
            cs       <= 1'b0;
            mosi     <= CMD_BYTE[7];
            div_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
         end else if (shifting || (state == S_HOLD)) begin
            if (tick) div_cnt <= '0;
            else      div_cnt <= div_cnt + CNT_W'(1);
            if ((state == S_HOLD) && tick) cs <= 1'b1;
            if (rise) begin
               sclk <= 1'b1;
               if (byte_end) begin
                  rd_data  <= {rx_shift, miso};
                  rd_valid <= 1'b1;
                  rd_last  <= (byte_cnt == len_q);
               end
            end
            if (fall) begin
               sclk    <= 1'b0;
               mosi    <= tx_shift[31];
               bit_cnt <= bit_end ? 5'd0 : bit_cnt + 5'd1;
               if (byte_end) byte_cnt <= byte_cnt + LEN_W'(1);
            end
         end else if (state == S_GAP) begin
            div_cnt <= div_cnt + CNT_W'(1);
         end
      end
   end

   // tx_shift drains to zero after the address, which keeps mosi low in DUMMY/READ
   always_ff @(posedge clk) begin
      if (accept) begin
         tx_shift <= {CMD_BYTE[6:0], req_addr, 1'b0};
         len_q    <= req_len;
      end else if (fall) begin
         tx_shift <= {tx_shift[30:0], 1'b0};
      end
      if (rise) rx_shift <= {rx_shift[5:0], miso};
   end

endmodule

// File: doc/spi_flash_burst.md
# spi_flash_burst

Parametrised burst-read SPI flash controller, the next-generation read engine for the boot/config flash path. It accepts one read request (24-bit address, 1..MAX_BURST bytes) over a valid/ready handshake and issues a single chip-select transaction in SPI mode 0. The transaction uses READ (0x03) or FAST_READ (0x0B + 8 dummy clocks), with a programmable SCLK divider. It streams the returned bytes to the system one strobe per byte, with a last-byte flag.

## Interface
- CLK_DIV, 1: SCLK half-period in clk cycles (H); legal range ≥1.
- MAX_BURST, 16: maximum bytes per request; power of two, ≥1.
- FAST_READ, 0: 0 selects cmd 0x03 with no dummy phase; 1 selects cmd 0x0B followed by 8 dummy SCLKs (D=8, else D=0).
- CS_GAP, 2: minimum clk cycles CS stays high between transactions; ≥1.
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  reset; one clock; reset is synchronous and active-high (asserted = 1).
- req_valid  in  1  read request present.
- req_ready  out  1  high iff in IDLE; request accepted on an edge where req_valid & req_ready.
- req_addr  in  24  flash byte address; latched at accept.
- req_len  in  max(1,$clog2(MAX_BURST))  byte count minus one; latched at accept.
- rd_data  out  8  received byte; valid only while rd_valid.
- rd_valid  out  1  one-cycle strobe per byte; no backpressure.
- rd_last  out  1  high with rd_valid on the final byte of the burst.
- sclk, mosi  out  1  SPI clock (idles 0) and controller data out, MSB first.
- miso  in  1  flash data out.
- cs  out  1  chip select, active low.

## Operation
- Reset values: state IDLE, sclk 0, mosi 0, cs 1, rd_data 0, rd_valid 0, rd_last 0, counters 0. req_ready reads 1 in IDLE, but requests are ignored on any edge with rstn=1.
- Reset mid-transaction aborts immediately. On the same edge, cs goes 1 and sclk goes 0, and no further rd_valid pulses occur.
- States: IDLE → CMD (8 bits) → ADDR (24 bits) → DUMMY (D bits, skipped when D=0) → READ (8·(req_len+1) bits) → HOLD → GAP → IDLE.
- Bit stream: the command byte, then address[23:0], MSB first. mosi is driven 0 during DUMMY and READ.
- Total bits: N = 32 + D + 8·(req_len+1).
- Shift register assembles MSB first from miso. The byte counter counts up to req_len, and rd_last = (byte index == latched req_len).
- req_valid while busy has no effect. req_addr and req_len may change freely after accept.
- Address wrap past 0xFFFFFF is the flash's behaviour; the controller only counts bytes.

## Timing
- E0 is the accept edge. At E0: cs←0 and mosi←bit 0 (cmd MSB).
- Bit k (0..N-1): sclk←1 at edge E0+(2k+1)H, and sclk←0 at E0+(2k+2)H. mosi←bit k+1 on that same falling edge.
- miso is sampled on each sclk←1 edge, i.e. the value present in the cycle before the edge. The flash updates it on the preceding falling edge.
- Byte j completes at bit k = 32+D+8j+7. rd_data is updated and rd_valid/rd_last are asserted on edge E0+(2k+1)H. They remain high for exactly one cycle, independent of CLK_DIV.
- After the last falling edge (E0+2NH), sclk stays 0. cs←1 at E0+(2N+1)H (H cycles CS hold).
- req_ready←1 at E0+(2N+1)H+CS_GAP. A new request may be accepted on that edge.
- With H=1, consecutive rd_valid pulses are 16 cycles apart. With general H, they are 16H cycles apart.

## Test plan
- CLK_DIV=1, FAST_READ=0, CS_GAP=2; request addr 0x012345, len 0; flash model returns 0xA5 → mosi shows 0x03 then 0x012345. A single rd_valid with rd_data=0xA5 and rd_last=1 occurs after edge E0+79. cs rises at E0+81, and req_ready is high at E0+83.
- len=MAX_BURST-1=15, model returns 0x00..0x0F → 16 strobes, 16 cycles apart, with data 0x00..0x0F. rd_last is asserted only on 0x0F; cs stays low throughout.
- FAST_READ=1, CLK_DIV=3, len 1 → cmd 0x0B and 8 dummy SCLKs with mosi=0. Sclk high and low phases are each 3 cycles. Bytes are correct; first rd_valid follows the rising edge of bit 47.
- Back-to-back: req_valid held high with two requests → the second is accepted exactly at req_ready rise. CS high time equals H+CS_GAP-H... i.e. cs high for exactly CS_GAP cycles before the second cs fall.
- Assert rstn for 1 cycle during ADDR → next edge: cs=1, sclk=0, mosi=0, no rd_valid. A fresh request after reset completes correctly.
- req_valid pulsed during READ with a different address → ignored. The data stream and timing are unchanged.
